// File: rtl/hack_video_gen.sv
// hack_video_gen
//   Raster timing and pixel serialiser for the Hack screen. It produces a
//   pixel enable, H/V sync and blanking for an NTSC or PAL line count. It
//   fetches screen words from a synchronous RAM and shifts them out as 8-bit
//   monochrome luminance. Bit 0 of each word is the leftmost pixel. A set
//   bit is black.
//
//   Ports
//     clk, reset      system clock, asynchronous active-high reset
//     pal             raster select (0 = NTSC, 1 = PAL), sampled at frame start
//     rd_addr, rd_en  screen RAM word address and one-clk read strobe
//     rd_data         RAM word, valid the clk after rd_en
//     ce_pix          pixel enable, one clk in CE_DIV
//     HBlank, HSync   horizontal blank and sync (active-high)
//     VBlank, VSync   vertical blank and sync (active-high)
//     video           luminance, 8'h00 during blanking
//     invert          (only with HACK_VIDEO_INVERT_EN) swaps black/white,
//                     sampled at frame start together with pal
//
//   RAM handshake: rd_en is high for exactly one clk, in the clk where the
//   divider equals CE_DIV-2. rd_addr is valid in that same clk. The RAM
//   returns rd_data in the following clk, which is the last clk of the pixel
//   period. The shift register captures rd_data on the tick edge that starts
//   the new word. No back-pressure exists.
//
//   Timing model: every pixel update happens on the "tick" edge, where the
//   divider wraps from CE_DIV-1 to 0. On that edge the sync, blank and video
//   outputs for the current hcount/vcount are registered, ce_pix is set for
//   one clk, and the counters move to the next pixel. All outputs therefore
//   change together, with no skew.
//
//   Word 0 of line 0 is prefetched at the end of the previous frame. So in
//   the first frame after reset, the first word of line 0 shows the
//   reset-cleared shift register rather than RAM contents.
module hack_video_gen #(
    parameter int CE_DIV       = 4,
    parameter int WORD_W       = 16,
    parameter int H_ACTIVE     = 512,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 48,
    parameter int H_TOTAL      = 640,
    parameter int V_ACTIVE     = 256,
    parameter int V_FP         = 3,
    parameter int V_SYNC       = 3,
    parameter int V_TOTAL_NTSC = 262,
    parameter int V_TOTAL_PAL  = 312,
    parameter int ADDR_W       = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pal,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [WORD_W-1:0] rd_data,
    output logic              ce_pix,
    output logic              HBlank,
    output logic              HSync,
    output logic              VBlank,
    output logic              VSync,
    output logic [7:0]        video
`ifdef HACK_VIDEO_INVERT_EN
    ,
    input  logic              invert
`endif
);
    localparam int V_MAX = (V_TOTAL_PAL > V_TOTAL_NTSC) ? V_TOTAL_PAL : V_TOTAL_NTSC;
    localparam int DIV_W = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
    // One extra bit so that region ends equal to the total still fit.
    localparam int H_W   = $clog2(H_TOTAL + 1);
    localparam int V_W   = $clog2(V_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST     = DIV_W'(CE_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_FETCH    = DIV_W'(CE_DIV - 2);
    localparam logic [H_W-1:0]    H_LAST       = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]    H_ACT        = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]    H_ACT_LAST   = H_W'(H_ACTIVE - 1);
    localparam logic [H_W-1:0]    H_SYNC_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]    H_SYNC_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [H_W-1:0]    H_WORD       = H_W'(WORD_W);
    localparam logic [H_W-1:0]    H_WORD_LAST  = H_W'(WORD_W - 1);
    localparam logic [V_W-1:0]    V_ACT        = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]    V_SYNC_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]    V_SYNC_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_W-1:0]    V_LAST_NTSC  = V_W'(V_TOTAL_NTSC - 1);
    localparam logic [V_W-1:0]    V_LAST_PAL   = V_W'(V_TOTAL_PAL - 1);
    localparam logic [ADDR_W-1:0] WORDS_LINE   = ADDR_W'(H_ACTIVE / WORD_W);

    logic [DIV_W-1:0]  div, div_n;
    logic [H_W-1:0]    hcount, hcount_n;
    logic [V_W-1:0]    vcount, vcount_n, v_last, line_next;
    logic              pal_latched, pal_latched_n;
    logic              tick, fetch_n, pix_active, word_start, pix_bit;
    logic [ADDR_W-1:0] addr_n;
    logic [WORD_W-1:0] sreg;
`ifdef HACK_VIDEO_INVERT_EN
    logic              inv_latched, inv_latched_n;
`endif

    always_comb begin
        v_last        = pal_latched ? V_LAST_PAL : V_LAST_NTSC;
        tick          = (div == DIV_LAST);
        div_n         = tick ? '0 : div + DIV_W'(1);
        hcount_n      = hcount;
        vcount_n      = vcount;
        pal_latched_n = pal_latched;
`ifdef HACK_VIDEO_INVERT_EN
        inv_latched_n = inv_latched;
`endif
        if (tick) begin
            if (hcount == H_LAST) begin
                hcount_n = '0;
                if (vcount == v_last) begin
                    vcount_n      = '0;
                    pal_latched_n = pal;
`ifdef HACK_VIDEO_INVERT_EN
                    inv_latched_n = invert;
`endif
                end else begin
                    vcount_n = vcount + V_W'(1);
                end
            end else begin
                hcount_n = hcount + H_W'(1);
            end
        end

        // Fetch decisions use next-state counters, so rd_en can be registered
        // for every CE_DIV >= 2. With CE_DIV = 2 the fetch clk follows a tick.
        line_next = (vcount_n == v_last) ? '0 : vcount_n + V_W'(1);
        fetch_n   = 1'b0;
        addr_n    = rd_addr;
        if (div_n == DIV_FETCH) begin
            if (hcount_n == H_LAST) begin
                // Prefetch word 0 of the coming line during its last pixel.
                if (line_next < V_ACT) begin
                    fetch_n = 1'b1;
                    addr_n  = ADDR_W'(line_next) * WORDS_LINE;
                end
            end else if ((vcount_n < V_ACT) && (hcount_n < H_ACT_LAST) &&
                         ((hcount_n % H_WORD) == H_WORD_LAST)) begin
                fetch_n = 1'b1;
                addr_n  = ADDR_W'(vcount_n) * WORDS_LINE +
                          ADDR_W'((hcount_n + H_W'(1)) / H_WORD);
            end
        end

        pix_active = (vcount < V_ACT) && (hcount < H_ACT);
        word_start = (vcount_n < V_ACT) && (hcount_n < H_ACT) &&
                     ((hcount_n % H_WORD) == '0);
`ifdef HACK_VIDEO_INVERT_EN
        pix_bit = sreg[0] ^ inv_latched;
`else
        pix_bit = sreg[0];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div         <= '0;
            hcount      <= '0;
            vcount      <= '0;
            pal_latched <= 1'b0;
`ifdef HACK_VIDEO_INVERT_EN
            inv_latched <= 1'b0;
`endif
            ce_pix      <= 1'b0;
            HBlank      <= 1'b1;
            HSync       <= 1'b0;
            VBlank      <= 1'b1;
            VSync       <= 1'b0;
            video       <= 8'h00;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            sreg        <= '0;
        end else begin
            div         <= div_n;
            hcount      <= hcount_n;
            vcount      <= vcount_n;
            pal_latched <= pal_latched_n;
`ifdef HACK_VIDEO_INVERT_EN
            inv_latched <= inv_latched_n;
`endif
            ce_pix      <= tick;
            rd_en       <= fetch_n;
            rd_addr     <= addr_n;
            if (tick) begin
                HBlank <= (hcount >= H_ACT);
                HSync  <= (hcount >= H_SYNC_START) && (hcount < H_SYNC_END);
                VBlank <= (vcount >= V_ACT);
                VSync  <= (vcount >= V_SYNC_START) && (vcount < V_SYNC_END);
                video  <= (!pix_active || pix_bit) ? 8'h00 : 8'hFF;
                // rd_data arrives in this clk when word_start is set.
                sreg   <= word_start ? rd_data : (sreg >> 1);
            end
        end
    end
endmodule

// File: doc/hack_video_gen.md
Name: hack_video_gen

Overview:
- Parametrised successor to the fixed Nand2Tetris video generator.
- Generates pixel-enable, H/V sync and blanking for a selectable NTSC/PAL raster. Fetches Hack screen words from a synchronous screen RAM and serialises them to an 8-bit monochrome video stream.
- Sits between the Hack CPU's screen memory and the emu top; outputs feed CE_PIXEL, VGA_HS/VS/DE and the colour mux directly.

Parameters:
- CE_DIV, 4: clk cycles per pixel; must be >=2.
- WORD_W, 16: screen word width in pixels.
- H_ACTIVE, 512: active pixels per line; must be a multiple of WORD_W.
- H_FP, 16: front porch, pixels.
- H_SYNC, 48: sync width, pixels.
- H_TOTAL, 640: pixels per line.
- V_ACTIVE, 256: active lines.
- V_FP, 3: front porch, lines.
- V_SYNC, 3: sync width, lines.
- V_TOTAL_NTSC, 262: lines per frame when pal=0.
- V_TOTAL_PAL, 312: lines per frame when pal=1.
- ADDR_W, 13: screen RAM address width; must satisfy 2^ADDR_W >= V_ACTIVE*H_ACTIVE/WORD_W.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- pal, in, 1: raster select, 0=NTSC, 1=PAL.
- rd_addr, out, ADDR_W: screen RAM word address.
- rd_en, out, 1: read strobe, one clk wide.
- rd_data, in, WORD_W: RAM data, valid the clk after rd_en.
- ce_pix, out, 1: pixel enable, one clk in CE_DIV.
- HBlank, out, 1: horizontal blank.
- HSync, out, 1: horizontal sync, active-high.
- VBlank, out, 1: vertical blank.
- VSync, out, 1: vertical sync, active-high.
- video, out, 8: luminance.

Behaviour:
- Reset values (async assert):
  - Divider, hcount and vcount = 0.
  - ce_pix=0, HSync=0, VSync=0, HBlank=1, VBlank=1, video=0.
  - rd_en=0, rd_addr=0, shift register=0, pal_latched=0.
  - Release is synchronous to clk; the first ce_pix occurs CE_DIV clks after release.
- Divider:
  - Counts 0..CE_DIV-1 and wraps.
  - ce_pix=1 when the divider equals CE_DIV-1. Registered.
- hcount:
  - Advances on ce_pix; wraps H_TOTAL-1 -> 0.
  - On wrap, vcount advances and wraps at V_TOTAL-1 -> 0.
  - V_TOTAL is selected by pal_latched.
- pal sampling: pal is sampled into pal_latched only when vcount wraps to 0. A mid-frame change has no effect until the next frame.
- Horizontal regions, in pixels from hcount=0:
  - Active: [0, H_ACTIVE).
  - HSync: [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - HBlank: 1 for hcount >= H_ACTIVE.
- Vertical regions, in lines from vcount=0:
  - Active: [0, V_ACTIVE).
  - VSync: [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - VBlank: 1 for vcount >= V_ACTIVE.
- Output alignment: all sync, blank and video outputs are registered and update on the same clk as ce_pix. Their relationship to each other is exact, with no skew.
- Fetch:
  - Condition: in an active line, in the clk where divider==CE_DIV-2 and (hcount+1) mod WORD_W == 0.
  - Exception: when hcount=H_TOTAL-1 and the next line is active, a fetch is issued for word 0 of the next line.
  - Action: assert rd_en for one clk with rd_addr = line*(H_ACTIVE/WORD_W) + word.
  - Words per frame: exactly V_ACTIVE*H_ACTIVE/WORD_W.
  - No fetch on blank lines.
- Shift register:
  - Loads rd_data on the ce_pix that starts a word.
  - Otherwise shifts right one bit per ce_pix; bit 0 is the leftmost pixel.
- Video mapping:
  - Pixel bit 1 -> video=8'h00 (black); bit 0 -> 8'hFF (white).
  - video=8'h00 whenever HBlank|VBlank.
- Last pixel: the last active pixel of a line (hcount=H_ACTIVE-1) shows bit WORD_W-1 of the final word. There is no fetch past the end of the active region.

Optional Feature:
- Macro: HACK_VIDEO_INVERT_EN.
- When defined:
  - Adds input port `invert`, 1 bit.
  - `invert` is latched at frame start together with pal.
  - When latched high, the video mapping is swapped: bit 1 -> 8'hFF, bit 0 -> 8'h00.
  - Blanking output stays 8'h00.
- When undefined: no port; the fixed mapping above applies.

Test Plan:
- Reset, defaults (CE_DIV=4, pal=0):
  - ce_pix period is 4 clks.
  - HSync high for hcount 528..575; HBlank high for hcount 512..639.
  - Frame is 262 lines; VSync covers lines 259..261.
- pal=1 held: frame is 312 lines; VSync covers lines 259..261.
- pal toggled at line 100: the current frame still ends at 262 lines; the next frame is 312 lines.
- RAM model with word n = n (16-bit):
  - Exactly 8192 rd_en pulses per frame, with addresses 0..8191 in order.
  - Line 1, pixel 0 reads from address 32.
  - Pixel values match the bit-0-first serialisation of each word.
- RAM all 16'h0001 at line 0: video=00 at pixel 0, FF at pixels 1..15, 00 at pixel 16.
- Assert reset mid-line (hcount=300, vcount=50): all outputs return to reset values asynchronously. After release, counting restarts at hcount=0, vcount=0.
